// File: rtl/dmap_cache_pkg.sv
// Shared types and width helpers for the direct-mapped, write-through cache controller.
package dmap_cache_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned INDEX_BITS_DEFAULT = 6;
  localparam int unsigned CNT_W              = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_WTHRU,
    ST_RESP
  } state_e;

  // CPU request captured at accept
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  // Tag occupies everything above the line index and the byte offset
  function automatic int unsigned tag_width(input int unsigned index_bits);
    return ADDR_W - index_bits - 2;
  endfunction

endpackage

// File: rtl/dmap_cache_array.sv
// Line storage: valid/tag/data arrays, synchronous write, combinational read, one-cycle clear-all.
module dmap_cache_array
  import dmap_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int unsigned TAG_W      = tag_width(INDEX_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_all,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid_c,
  output logic [TAG_W-1:0]      rd_tag_c,
  output logic [DATA_W-1:0]     rd_data_c
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // A write coinciding with reset is dropped so an abandoned fill leaves no trace
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid_c = valid_q[rd_idx];
  assign rd_tag_c   = tag_q[rd_idx];
  assign rd_data_c  = data_q[rd_idx];

endmodule

// File: rtl/dmap_cache_ctrl.sv
// Direct-mapped one-word-line cache, write-through / no-allocate, with deferred flush.
// Optional hit/miss counters enabled by defining DMAP_CACHE_STATS_EN.
module dmap_cache_ctrl
  import dmap_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              flush,
  output logic              cpu_busy,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMAP_CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`endif
);

  localparam int unsigned TAG_W = tag_width(INDEX_BITS);

  state_e            state_q, state_d;
  cpu_req_t          req_q, req_d;
  logic              flush_pend_q, flush_pend_d;
  logic              wr_hit_q, wr_hit_d;
  logic              cpu_busy_q, cpu_busy_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic                  arr_clr, arr_we;
  logic [DATA_W-1:0]     arr_wdata;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_W-1:0]     rd_data;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  lookup_hit;

  assign req_idx    = req_q.addr[INDEX_BITS+1:2];
  assign req_tag    = req_q.addr[ADDR_W-1:INDEX_BITS+2];
  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  dmap_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (arr_clr),
    .we         (arr_we),
    .wr_idx     (req_idx),
    .wr_tag     (req_tag),
    .wr_data    (arr_wdata),
    .rd_idx     (req_idx),
    .rd_valid_c (rd_valid),
    .rd_tag_c   (rd_tag),
    .rd_data_c  (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    flush_pend_d = flush_pend_q;
    wr_hit_d     = wr_hit_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    arr_clr      = 1'b0;
    arr_we       = 1'b0;
    arr_wdata    = mem_rdata;

    unique case (state_q)
      ST_IDLE: begin
        // Flush (fresh or deferred) wins over a request arriving in the same cycle
        if (flush || flush_pend_q) begin
          arr_clr      = 1'b1;
          flush_pend_d = 1'b0;
        end else if (cpu_req) begin
          req_d.we    = cpu_we;
          req_d.addr  = cpu_addr;
          req_d.wdata = cpu_wdata;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (req_q.we) begin
          wr_hit_d    = lookup_hit;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = req_q.addr;
          mem_wdata_d = req_q.wdata;
          state_d     = ST_WTHRU;
        end else if (lookup_hit) begin
          cpu_rdata_d = rd_data;
          cpu_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = req_q.addr;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_ack) begin
          arr_we      = 1'b1;
          cpu_rdata_d = mem_rdata;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_WTHRU: begin
        if (mem_ack) begin
          arr_we      = wr_hit_q;
          arr_wdata   = req_q.wdata;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush && (state_q != ST_IDLE)) begin
      flush_pend_d = 1'b1;
    end

    cpu_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      flush_pend_q <= 1'b0;
      wr_hit_q     <= 1'b0;
      cpu_busy_q   <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      flush_pend_q <= flush_pend_d;
      wr_hit_q     <= wr_hit_d;
      cpu_busy_q   <= cpu_busy_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign cpu_busy  = cpu_busy_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DMAP_CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // One count per lookup, saturating
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/dmap_cache_ctrl.md
DMAP_CACHE_CTRL -- requirements
Module: dmap_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, log2 of line count (64 one-word lines).
REQ-002 SHALL have clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 SHALL have cpu_req  input  1  request valid.
REQ-005 SHALL have cpu_we  input  1  0 = read, 1 = write.
REQ-006 SHALL have cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have cpu_wdata  input  32  write data.
REQ-008 SHALL have flush  input  1  invalidate-all request.
REQ-009 SHALL have cpu_busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have cpu_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have cpu_rdata  output  32  read data, valid while cpu_ready is high.
REQ-012 SHALL have mem_req, mem_we  output  1 each  backing-memory request and direction.
REQ-013 SHALL have mem_addr, mem_wdata  output  32 each  backing-memory address and data.
REQ-014 SHALL have mem_ack  input  1  and mem_rdata  input  32  backing-memory completion and read data.

Function
REQ-015 SHALL split the address as index = addr[INDEX_BITS+1:2] and tag = addr[31:INDEX_BITS+2]; each line holds valid, tag and one 32-bit word.
REQ-016 SHALL accept a request when cpu_req is high and cpu_busy is low, and SHALL capture cpu_we, cpu_addr and cpu_wdata at that edge.
REQ-017 SHALL implement states IDLE, LOOKUP, FILL, WTHRU and RESP.
REQ-018 SHALL move IDLE->LOOKUP on accept; LOOKUP compares the captured tag with the stored tag and valid bit.
REQ-019 SHALL treat a read hit as LOOKUP->RESP, with cpu_ready asserted in RESP and cpu_rdata equal to the line data, giving 3 cycles from accept to cpu_ready.
REQ-020 SHALL treat a read miss as LOOKUP->FILL, holding mem_req=1, mem_we=0, mem_addr=captured address until mem_ack; on mem_ack it SHALL write data, tag and valid=1 to the line and go to RESP with cpu_rdata = mem_rdata.
REQ-021 SHALL make writes write-through and no-allocate: LOOKUP->WTHRU; a hit updates the line data; WTHRU holds mem_req=1, mem_we=1 with captured address and data until mem_ack, then goes to RESP.
REQ-022 SHALL return from RESP to IDLE unconditionally after one cycle, with cpu_ready high for exactly that cycle.
REQ-023 SHALL keep mem_req low in IDLE, LOOKUP and RESP, and SHALL hold mem_addr, mem_wdata and mem_we stable while mem_req is high.
REQ-024 SHALL, when flush is high in IDLE, clear all valid bits in that cycle and SHALL NOT accept cpu_req in that cycle (flush has priority).
REQ-025 SHALL, when flush is high outside IDLE, set a pending flag and perform the flush in the first IDLE cycle, before accepting any request.
REQ-026 SHALL ignore mem_ack in every state except FILL and WTHRU.

Reset
REQ-027 SHALL, on rst, go to IDLE, clear all valid bits and the pending flush, and drive cpu_ready=0, cpu_busy=0, mem_req=0, mem_we=0, cpu_rdata=0, mem_addr=0 and mem_wdata=0.
REQ-028 SHALL, when rst is asserted mid-transaction, abandon the transaction, produce no cpu_ready and not update any line.

Configuration
REQ-029 SHALL, with DMAP_CACHE_STATS_EN defined, add outputs hit_count[15:0] and miss_count[15:0], each incremented once per LOOKUP (reads and writes), saturating at 16'hFFFF and cleared by rst.
REQ-030 SHALL, without DMAP_CACHE_STATS_EN, have neither the counters nor their ports, with all other behaviour identical.

Structure
REQ-031 SHALL place the state enum, the INDEX_BITS default and the tag-width derivation in package dmap_cache_pkg.
REQ-032 SHALL put the storage (valid/tag/data arrays: synchronous write, combinational read, single-cycle clear-all of valid) in sub-module dmap_cache_array.

Verification
REQ-033 SHALL cover: after reset, read 0x0000_0040 with mem_ack 2 cycles after mem_req and mem_rdata=0xDEAD_BEEF -> one mem_req read, then cpu_ready with 0xDEAD_BEEF.
REQ-034 SHALL cover: repeating that read -> no mem_req, cpu_ready 3 cycles after accept, data 0xDEAD_BEEF.
REQ-035 SHALL cover: write 0x1234_5678 to 0x0000_0040 -> mem_req/mem_we with that address and data; a following read hits and returns 0x1234_5678.
REQ-036 SHALL cover: read 0x0000_0140 (same index 16, different tag) -> miss, and the line is refilled.
REQ-037 SHALL cover: flush asserted during FILL -> the fill completes, the flush runs in the next IDLE cycle, and a following read of 0x0000_0040 misses.
REQ-038 SHALL cover: rst asserted while in WTHRU -> mem_req low next cycle, no cpu_ready, all lines invalid; with DMAP_CACHE_STATS_EN defined, the counters read 0.
